maze_mem_arbiter: RTL

Single-port access scheduler for the 16x16 maze bit memory. Three requesters share the memory: the map loader, the maze-solver controller (reads cells and writes visited marks) and the move-replay unit. The block also owns a sweep engine that clears the whole array between runs. It sits between those three units and the 256x1 memory macro, and it is the only block that drives memory address, write enable and write data.

---
 rtl/maze_pkg.sv | 21 ++
 rtl/rr_arb2.sv | 32 +++
 rtl/maze_mem_arbiter.sv | 136 +++++++++++++
 3 files changed

// File: rtl/maze_pkg.sv
// Shared types and constants for the maze memory access scheduler.
package maze_pkg;

  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DEPTH  = 256;

  localparam int unsigned REQ_LOAD   = 0;
  localparam int unsigned REQ_SOLVE  = 1;
  localparam int unsigned REQ_REPLAY = 2;

  localparam logic CELL_FREE = 1'b0;
  localparam logic CELL_MARK = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SERVE = 2'd2,
    ST_CLEAR = 2'd3
  } arb_state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; the pointer moves to the requester that was not
// just granted, so a lone requester is still granted every cycle.
module rr_arb2 (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_en,
  input  logic [1:0] i_req,
  output logic [1:0] o_gnt
);

  logic r_ptr;  // 0: requester 0 has priority

  always_comb begin
    o_gnt = 2'b00;
    if (i_en) begin
      if (r_ptr == 1'b0) begin
        o_gnt = i_req[0] ? 2'b01 : {i_req[1], 1'b0};
      end else begin
        o_gnt = i_req[1] ? 2'b10 : {1'b0, i_req[0]};
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_ptr <= 1'b0;
    end else if (|o_gnt) begin
      r_ptr <= o_gnt[0];
    end
  end

endmodule

// File: rtl/maze_mem_arbiter.sv
// Single-port scheduler for the 256x1 maze memory: loader phase, solver/replay
// round-robin service, and a full-array clear sweep.
module maze_mem_arbiter
  import maze_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst,        // synchronous, active-low
  input  logic              i_load_start,
  input  logic              i_load_done,
  input  logic              i_clr_start,
  output logic              o_clr_done,
  output logic              o_busy,
  input  logic [2:0]        i_req,
  input  logic [2:0]        i_we,
  input  logic [3:0]        i_x0,
  input  logic [3:0]        i_y0,
  input  logic [3:0]        i_x1,
  input  logic [3:0]        i_y1,
  input  logic [3:0]        i_x2,
  input  logic [3:0]        i_y2,
  input  logic [2:0]        i_wd,
  output logic [2:0]        o_gnt,
  output logic [2:0]        o_rvalid,
  output logic              o_rdata,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic              o_mem_we,
  output logic              o_mem_wd,
  output logic              o_mem_re,
  input  logic              i_mem_rd
);

  arb_state_t r_state, w_state_nxt;
  logic [8:0] r_sweep;
  logic       r_clr_done;
  logic [2:0] r_rvalid;
  logic [1:0] w_rr_gnt;
  logic       w_serve;
  logic       w_sweep_last;
  logic       w_any_rr_req;

  assign w_serve      = (r_state == ST_SERVE);
  assign w_sweep_last = (r_state == ST_CLEAR) && (r_sweep == 9'(DEPTH - 1));
  assign w_any_rr_req = i_req[REQ_SOLVE] | i_req[REQ_REPLAY];

  rr_arb2 u_rr_arb2 (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_en  (w_serve),
    .i_req (i_req[2:1]),
    .o_gnt (w_rr_gnt)
  );

  always_comb begin
    o_gnt = 3'b000;
    if (r_state == ST_LOAD) begin
      o_gnt[REQ_LOAD] = i_req[REQ_LOAD];
    end else if (w_serve) begin
      o_gnt[2:1] = w_rr_gnt;
    end
  end

  always_comb begin
    o_mem_addr = '0;
    o_mem_we   = 1'b0;
    o_mem_wd   = 1'b0;
    o_mem_re   = 1'b0;
    if (r_state == ST_CLEAR) begin
      o_mem_addr = r_sweep[ADDR_W-1:0];
      o_mem_we   = 1'b1;
      o_mem_wd   = CELL_FREE;
    end else if (o_gnt[REQ_LOAD]) begin
      o_mem_addr = {i_y0, i_x0};
      o_mem_we   = i_we[REQ_LOAD];
      o_mem_wd   = i_wd[REQ_LOAD];
      o_mem_re   = ~i_we[REQ_LOAD];
    end else if (o_gnt[REQ_SOLVE]) begin
      o_mem_addr = {i_y1, i_x1};
      o_mem_we   = i_we[REQ_SOLVE];
      o_mem_wd   = i_wd[REQ_SOLVE];
      o_mem_re   = ~i_we[REQ_SOLVE];
    end else if (o_gnt[REQ_REPLAY]) begin
      o_mem_addr = {i_y2, i_x2};
      o_mem_we   = i_we[REQ_REPLAY];
      o_mem_wd   = i_wd[REQ_REPLAY];
      o_mem_re   = ~i_we[REQ_REPLAY];
    end
  end

  // Clear beats load when both open in the same cycle; SERVE leaves only after its grant.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (i_clr_start)       w_state_nxt = ST_CLEAR;
        else if (i_load_start) w_state_nxt = ST_LOAD;
        else if (w_any_rr_req) w_state_nxt = ST_SERVE;
      end
      ST_LOAD: begin
        if (i_load_done) w_state_nxt = ST_IDLE;
      end
      ST_SERVE: begin
        if (i_clr_start)        w_state_nxt = ST_CLEAR;
        else if (i_load_start)  w_state_nxt = ST_LOAD;
        else if (!w_any_rr_req) w_state_nxt = ST_IDLE;
      end
      ST_CLEAR: begin
        if (w_sweep_last) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state    <= ST_IDLE;
      r_sweep    <= 9'd0;
      r_clr_done <= 1'b0;
      r_rvalid   <= 3'b000;
    end else begin
      r_state    <= w_state_nxt;
      r_clr_done <= w_sweep_last;
      r_rvalid   <= o_gnt & ~i_we;
      if ((r_state == ST_CLEAR) && !w_sweep_last) begin
        r_sweep <= r_sweep + 9'd1;
      end else begin
        r_sweep <= 9'd0;
      end
    end
  end

  assign o_rvalid   = r_rvalid;
  assign o_rdata    = (|r_rvalid) & i_mem_rd;
  assign o_clr_done = r_clr_done;
  assign o_busy     = (r_state == ST_LOAD) || (r_state == ST_CLEAR);

endmodule
